// File: rtl/jtag_cmd_decoder.sv
// Frames JTAG command bytes into single-word debug memory accesses and serialises read data back out.
// Optional feature macro: JTAG_CMD_AUTOINC_EN (WRITE_NEXT 0x03 / READ_NEXT 0x04 with address auto-increment).
module jtag_cmd_decoder #(
  parameter int DW = 8,
  parameter int AW = 16,
  parameter int MW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] byte_in,
  input  logic          byte_valid,
  input  logic          rd_ack,
  output logic [DW-1:0] rd_byte,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [MW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [MW-1:0] mem_rdata,
  output logic          busy,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR0   = 3'd1,
    ADDR1   = 3'd2,
    DATA    = 3'd3,
    REQ     = 3'd4,
    WAIT_RD = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic          op_write, op_write_nxt;
  logic [AW-1:0] addr_asm, addr_asm_nxt;
  logic [MW-1:0] wdata_asm, wdata_asm_nxt;
  logic [1:0]    cnt, cnt_nxt;
  logic [MW-1:0] rbuf, rbuf_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          err_nxt;
  logic          load_req;
  logic [AW-1:0] mem_addr_nxt;
  logic [MW-1:0] mem_wdata_nxt;
  logic          mem_we_nxt;
  logic [DW-1:0] rd_byte_nxt;

  always_comb begin
    state_nxt     = state;
    op_write_nxt  = op_write;
    addr_asm_nxt  = addr_asm;
    wdata_asm_nxt = wdata_asm;
    cnt_nxt       = cnt;
    rbuf_nxt      = rbuf;
    err_nxt       = err;
    load_req      = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_we_nxt    = mem_we;

    if (rd_ack) begin
      idx_nxt = idx + 2'd1;
    end else begin
      idx_nxt = idx;
    end

    case (state)
      IDLE: begin
        if (byte_valid) begin
          case (byte_in)
            8'h00: state_nxt = IDLE;
            8'h01: begin
              op_write_nxt = 1'b1;
              state_nxt    = ADDR0;
            end
            8'h02: begin
              op_write_nxt = 1'b0;
              state_nxt    = ADDR0;
            end
            8'hFF: begin
              err_nxt  = 1'b0;
              rbuf_nxt = {MW{1'b0}};
              idx_nxt  = 2'd0;
            end
`ifdef JTAG_CMD_AUTOINC_EN
            8'h03: begin
              op_write_nxt = 1'b1;
              cnt_nxt      = 2'd0;
              state_nxt    = DATA;
            end
            8'h04: begin
              op_write_nxt = 1'b0;
              load_req     = 1'b1;
              state_nxt    = REQ;
            end
`endif
            default: err_nxt = 1'b1;
          endcase
        end else begin
          state_nxt = IDLE;
        end
      end
      ADDR0: begin
        if (byte_valid) begin
          addr_asm_nxt[7:0] = byte_in;
          state_nxt         = ADDR1;
        end else begin
          state_nxt = ADDR0;
        end
      end
      ADDR1: begin
        if (byte_valid) begin
          addr_asm_nxt[15:8] = byte_in;
          if (op_write) begin
            cnt_nxt   = 2'd0;
            state_nxt = DATA;
          end else begin
            load_req  = 1'b1;
            state_nxt = REQ;
          end
        end else begin
          state_nxt = ADDR1;
        end
      end
      DATA: begin
        if (byte_valid) begin
          wdata_asm_nxt[{cnt, 3'b000} +: 8] = byte_in;
          cnt_nxt = cnt + 2'd1;
          if (cnt == 2'd3) begin
            load_req  = 1'b1;
            state_nxt = REQ;
          end else begin
            state_nxt = DATA;
          end
        end else begin
          state_nxt = DATA;
        end
      end
      REQ: begin
        // Bytes arriving while a request is outstanding cannot be queued.
        if (byte_valid) begin
          err_nxt = 1'b1;
        end else begin
          err_nxt = err;
        end
        if (mem_gnt) begin
          state_nxt = op_write ? IDLE : WAIT_RD;
`ifdef JTAG_CMD_AUTOINC_EN
          addr_asm_nxt = mem_addr + {{(AW-1){1'b0}}, 1'b1};
`endif
        end else begin
          state_nxt = REQ;
        end
      end
      WAIT_RD: begin
        if (byte_valid) begin
          err_nxt = 1'b1;
        end else begin
          err_nxt = err;
        end
        if (mem_rvalid) begin
          rbuf_nxt  = mem_rdata;
          idx_nxt   = 2'd0;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_RD;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load_req) begin
      mem_addr_nxt  = addr_asm_nxt;
      mem_wdata_nxt = wdata_asm_nxt;
      mem_we_nxt    = op_write_nxt;
    end else begin
      mem_we_nxt = mem_we;
    end

    rd_byte_nxt = rbuf_nxt[{idx_nxt, 3'b000} +: DW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_write  <= 1'b0;
      addr_asm  <= {AW{1'b0}};
      wdata_asm <= {MW{1'b0}};
      cnt       <= 2'd0;
      rbuf      <= {MW{1'b0}};
      idx       <= 2'd0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {AW{1'b0}};
      mem_wdata <= {MW{1'b0}};
      busy      <= 1'b0;
      rd_byte   <= {DW{1'b0}};
    end else begin
      state     <= state_nxt;
      op_write  <= op_write_nxt;
      addr_asm  <= addr_asm_nxt;
      wdata_asm <= wdata_asm_nxt;
      cnt       <= cnt_nxt;
      rbuf      <= rbuf_nxt;
      idx       <= idx_nxt;
      err       <= err_nxt;
      mem_req   <= (state_nxt == REQ);
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      busy      <= (state_nxt != IDLE);
      rd_byte   <= rd_byte_nxt;
    end
  end

endmodule
